// File: rtl/eeprom_mitm_ctrl_if.sv
// Bus-side signal bundle for the EEPROM interception controller: synchronized
// inputs from the edge detectors and the controls driven to the MISO/MOSI muxes.
interface eeprom_mitm_ctrl_if #(
    parameter int MODE_WIDTH = 3
);
    logic                  ss_active;
    logic                  bit_valid;
    logic                  mosi_bit;
    logic                  mode_next;
    logic [MODE_WIDTH-1:0] mode;
    logic                  comm_active;
    logic                  miso_sel;
    logic                  mosi_sel;
    logic                  inj_bit;
    logic                  frame_done;
    logic                  frame_err;
    logic [2:0]            last_opcode;
    logic [8:0]            last_addr;

    modport master (
        output ss_active, bit_valid, mosi_bit, mode_next,
        input  mode, comm_active, miso_sel, mosi_sel, inj_bit,
               frame_done, frame_err, last_opcode, last_addr
    );

    modport slave (
        input  ss_active, bit_valid, mosi_bit, mode_next,
        output mode, comm_active, miso_sel, mosi_sel, inj_bit,
               frame_done, frame_err, last_opcode, last_addr
    );
endinterface

// File: rtl/eeprom_mitm_ctrl.sv
// Per-frame interception controller for the 20-bit 3-wire EEPROM bus: tracks frame
// position, holds the attack mode and substitutes the data byte on MISO or MOSI.
module eeprom_mitm_ctrl #(
    parameter int         MODE_WIDTH  = 3,
    parameter logic [7:0] SUB_DATA    = 8'hff,
    parameter logic [8:0] TARGET_ADDR = 9'h120,
    parameter logic [2:0] OPC_READ    = 3'b110,
    parameter logic [2:0] OPC_WRITE   = 3'b101
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    eeprom_mitm_ctrl_if.slave  bus
);

    localparam logic [2:0] ST_SKIP = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_TAIL = 3'd4;

    logic [2:0]            state;
    logic [4:0]            bit_cnt;
    logic [11:0]           hdr_sr;
    logic [7:0]            data_sr;
    logic [MODE_WIDTH-1:0] mode_q;
    logic                  mode_pend;
    logic                  comm_q;
    logic                  miso_sel_q;
    logic                  mosi_sel_q;
    logic                  done_q;
    logic                  err_q;
    logic [2:0]            last_opc_q;
    logic [8:0]            last_addr_q;

    logic [11:0] hdr_next;
    logic        is_read;
    logic        is_write;
    logic        hit;
    logic [5:0]  cnt_final;
    logic        in_frame;

    function automatic logic [MODE_WIDTH-1:0] step_mode(input logic [MODE_WIDTH-1:0] m);
        return (m >= MODE_WIDTH'(3)) ? '0 : m + MODE_WIDTH'(1);
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        hdr_next  = {hdr_sr[10:0], bus.mosi_bit};
        is_read   = (hdr_next[11:9] == OPC_READ);
        is_write  = (hdr_next[11:9] == OPC_WRITE);
        hit       = 1'b0;
        case (mode_q)
            MODE_WIDTH'(1): hit = is_read;
            MODE_WIDTH'(2): hit = is_read && (hdr_next[8:0] == TARGET_ADDR);
            MODE_WIDTH'(3): hit = is_write;
            default:        hit = 1'b0;
        endcase
        // A bit arriving with the SS fall is counted before the frame is closed.
        cnt_final = {1'b0, bit_cnt} + 6'(bus.bit_valid);
        in_frame  = (state == ST_HDR) || (state == ST_DATA) || (state == ST_TAIL);
    end

    // NOTE: reset is synchronous and active-low, and all state updates use
    // non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state       <= bus.ss_active ? ST_SKIP : ST_IDLE;
            bit_cnt     <= '0;
            hdr_sr      <= '0;
            data_sr     <= '0;
            mode_q      <= '0;
            mode_pend   <= 1'b0;
            comm_q      <= 1'b0;
            miso_sel_q  <= 1'b0;
            mosi_sel_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_opc_q  <= '0;
            last_addr_q <= '0;
        end else begin
            comm_q <= bus.ss_active;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                ST_SKIP: begin
                    if (bus.mode_next) mode_pend <= 1'b1;
                    if (!bus.ss_active) begin
                        state     <= ST_IDLE;
                        mode_pend <= 1'b0;
                        if (mode_pend || bus.mode_next) mode_q <= step_mode(mode_q);
                    end
                end
                ST_IDLE: begin
                    if (bus.mode_next) mode_q <= step_mode(mode_q);
                    if (bus.ss_active) begin
                        state   <= ST_HDR;
                        bit_cnt <= '0;
                        hdr_sr  <= '0;
                    end
                end
                ST_HDR: begin
                    if (bus.bit_valid) begin
                        hdr_sr  <= hdr_next;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd11) begin
                            state <= ST_DATA;
                            if (hit) begin
                                data_sr    <= SUB_DATA;
                                miso_sel_q <= is_read;
                                mosi_sel_q <= !is_read;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.bit_valid) begin
                        data_sr <= {data_sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd19) begin
                            state      <= ST_TAIL;
                            miso_sel_q <= 1'b0;
                            mosi_sel_q <= 1'b0;
                        end
                    end
                end
                ST_TAIL: begin
                    if (bus.bit_valid && (bit_cnt != 5'd31)) bit_cnt <= bit_cnt + 5'd1;
                end
                default: state <= ST_IDLE;
            endcase

            // Frame close overrides the per-state updates above.
            if (in_frame) begin
                if (bus.mode_next) mode_pend <= 1'b1;
                if (!bus.ss_active) begin
                    state      <= ST_IDLE;
                    miso_sel_q <= 1'b0;
                    mosi_sel_q <= 1'b0;
                    mode_pend  <= 1'b0;
                    if (mode_pend || bus.mode_next) mode_q <= step_mode(mode_q);
                    if (cnt_final == 6'd20) begin
                        done_q      <= 1'b1;
                        last_opc_q  <= hdr_sr[11:9];
                        last_addr_q <= hdr_sr[8:0];
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.mode        = mode_q;
    assign bus.comm_active = comm_q;
    assign bus.miso_sel    = miso_sel_q;
    assign bus.mosi_sel    = mosi_sel_q;
    assign bus.inj_bit     = data_sr[7];
    assign bus.frame_done  = done_q;
    assign bus.frame_err   = err_q;
    assign bus.last_opcode = last_opc_q;
    assign bus.last_addr   = last_addr_q;

endmodule

// File: doc/eeprom_mitm_ctrl.md
# eeprom_mitm_ctrl

Per-frame interception controller for the proprietary 3-wire EEPROM bus (20-bit frames: 3-bit opcode, 9-bit address, 8-bit data, MSB first). It sits between the synchronized bus-input edge detectors and the MISO/MOSI output muxes. It tracks frame position and holds the active attack mode. At the data phase of each frame, it decides whether to substitute the data byte on MISO (reads) or MOSI (writes).

## Interface
- MODE_WIDTH, 3, width of `mode` output (modes 0-3 used)
- SUB_DATA, 8'hff, byte injected on substitution
- TARGET_ADDR, 9'h120, address matched in mode 2
- OPC_READ, 3'b110, read opcode
- OPC_WRITE, 3'b101, write opcode
- sys_clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- ss_active  in  1  synchronized SS, high during frame
- bit_valid  in  1  one-cycle pulse per synchronized SCLK rising edge
- mosi_bit  in  1  synchronized MOSI, valid with bit_valid
- mode_next  in  1  debounced mode-button pulse
- mode  out  MODE_WIDTH  current mode: 0 FORWARD, 1 SUB_READ_ALL, 2 SUB_READ_ADDR, 3 SUB_WRITE
- comm_active  out  1  registered ss_active (LED)
- miso_sel / mosi_sel  out  1  1 = drive injected bit instead of forwarding
- inj_bit  out  1  bit to inject
- frame_done  out  1  pulse: frame of exactly 20 bits ended
- frame_err  out  1  pulse: frame ended with bit count ≠ 20
- last_opcode  out  3  opcode of last completed frame
- last_addr  out  9  address of last completed frame

## Operation
- States: SKIP, IDLE, HDR, DATA, TAIL.
- Reset: all outputs 0. `mode` = 0, bit counter = 0. Next state is SKIP if ss_active = 1, else IDLE.
- SKIP: wait for ss_active = 0, then go to IDLE. Never join a frame already in progress.
- IDLE → HDR on ss_active = 1. Clear the bit counter (5 bits) and the 12-bit header shift register.
- HDR: each bit_valid shifts mosi_bit into the header and increments the counter. On the 12th bit_valid, evaluate `hit`:
  - mode 0: never.
  - mode 1: opcode == OPC_READ.
  - mode 2: opcode == OPC_READ and addr == TARGET_ADDR.
  - mode 3: opcode == OPC_WRITE.
- On hit, load an 8-bit data shift register with SUB_DATA. Assert `miso_sel` (read) or `mosi_sel` (write), then enter DATA.
- DATA: each bit_valid shifts the data register left. `inj_bit` is always data_sr[7]. On the 20th bit_valid, drop the selects and enter TAIL.
- TAIL: further bit_valid pulses only increment the counter, saturating at 31. No injection.
- Frame end: ss_active = 0 in HDR, DATA or TAIL returns to IDLE.
  - Counter == 20: pulse frame_done and latch last_opcode/last_addr.
  - Otherwise: pulse frame_err; last_* are unchanged.
- Mode stepping: mode_next increments `mode` modulo 4.
  - In IDLE: applied immediately.
  - In HDR/DATA/TAIL/SKIP: latched as pending and applied on the cycle ss_active is seen low. Any number of presses within one frame yields one step.
  - mode_next in the same cycle as ss_active falls counts as pending.
  - A mode change never alters the hit decision of the frame in progress.

## Timing
- comm_active: ss_active delayed 1 cycle.
- Selects assert 1 cycle after the 12th bit_valid. `inj_bit` = SUB_DATA[7] in that same cycle, ahead of the next SCLK falling edge (which requires SCLK half-period ≥ 3 sys_clk).
- `inj_bit` updates 1 cycle after each bit_valid in DATA.
- Selects deassert 1 cycle after the 20th bit_valid, or 1 cycle after ss_active is seen low, whichever comes first.
- frame_done/frame_err: single pulse, 1 cycle after ss_active is seen low.
- last_* update in the same cycle as the frame_done pulse.
- bit_valid and ss_active falling in the same cycle: count the bit first, then end the frame.
- Reset mid-frame takes priority over everything: selects low the next cycle, then SKIP.

## Test plan
- Reset, mode 0, read frame 110/0x09a/miso 0xa3 → selects stay 0; frame_done pulse; last_opcode = 6, last_addr = 0x09a; comm_active follows SS by 1 cycle.
- mode_next in IDLE → mode = 1. Read frame 110/0x120 → miso_sel high from 1 cycle after the 12th bit_valid to 1 cycle after the 20th; inj_bit sequence = 1,1,1,1,1,1,1,1 (0xff); mosi_sel = 0.
- Mode 2: read 0x09a → no select. Read 0x120 → miso_sel with 0xff. With SUB_DATA = 8'h5a, the sampled inj_bit sequence = 0,1,0,1,1,0,1,0.
- Mode 3: write frame 101/0x037/0x6d → mosi_sel asserted, injected byte = SUB_DATA. Read frame → no select.
- mode_next pulsed 3 times mid-frame in mode 3 → mode stays 3 until SS low, then becomes 0 (wrap), only once. Pulse on the SS-fall cycle → applied.
- Mode 1, SS drops after 15 bits → miso_sel low next cycle; frame_err pulse; no frame_done; last_* unchanged.
- rst_n low mid-frame with SS high → all outputs 0, no select for the rest of that frame; the next full frame is handled normally.
